// File: rtl/io_bus_master.sv
// io_bus_master
// -----------------------------------------------------------------------------
// CPU-side initiator for the 8-bit I/O register bus. Takes one read, write,
// set-bit or clear-bit request at a time from the execute stage, sequences
// cs/we/oe/address/data against the I/O register file (which acts on the
// falling clock edge), and reports completion with a one-cycle rsp_valid pulse.
//
// Ports
//   clk, reset      system clock; synchronous active-high reset
//   req_valid/ready request handshake; ready only in IDLE and out of reset
//   req_op          00 read, 01 write, 10 set bit, 11 clear bit
//   req_addr        target register
//   req_wdata       write data (op 01)
//   req_bit         bit index for set/clear and for rsp_bit
//   rsp_valid       one-cycle completion pulse
//   rsp_rdata       read value (pre-modify for set/clear, 0 for write)
//   rsp_bit         rsp_rdata[req_bit]
//   rsp_err         illegal request
//   cs, we, oe      registered bus strobes
//   address         registered bus address, holds its value in IDLE
//   data            bidirectional bus data, driven only while writing
//
// Configuration
//   IO_BUS_RMW_EN   when defined, ops 10/11 do a read-modify-write; when
//                   undefined they are rejected through the error response.
// -----------------------------------------------------------------------------
module io_bus_master #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [1:0]                    req_op,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  input  logic [DATA_WIDTH-1:0]         req_wdata,
  input  logic [$clog2(DATA_WIDTH)-1:0] req_bit,
  output logic                          rsp_valid,
  output logic [DATA_WIDTH-1:0]         rsp_rdata,
  output logic                          rsp_bit,
  output logic                          rsp_err,
  output logic                          cs,
  output logic                          we,
  output logic                          oe,
  output logic [ADDR_WIDTH-1:0]         address,
  inout  wire  [DATA_WIDTH-1:0]         data
);

  localparam int BIT_W = $clog2(DATA_WIDTH);

  localparam logic [1:0] OP_RD  = 2'b00;
  localparam logic [1:0] OP_WR  = 2'b01;
`ifdef IO_BUS_RMW_EN
  localparam logic [1:0] OP_SET = 2'b10;
  localparam logic [1:0] OP_CLR = 2'b11;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_ADDR = 2'd1,
    RD_DATA = 2'd2,
    WR      = 2'd3
  } state_t;

  state_t                  state_q, state_d;
  logic [BIT_W-1:0]        bit_q, bit_d;
  logic [ADDR_WIDTH-1:0]   address_q, address_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic                    cs_q, cs_d;
  logic                    we_q, we_d;
  logic                    oe_q, oe_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                    rsp_bit_q, rsp_bit_d;
  logic                    rsp_err_q, rsp_err_d;
  logic                    accept_s;
`ifdef IO_BUS_RMW_EN
  logic [1:0]              op_q, op_d;
  // Pre-modify value, held until the response so rsp_rdata only changes
  // together with rsp_valid.
  logic [DATA_WIDTH-1:0]   rmw_q, rmw_d;
  logic [DATA_WIDTH-1:0]   rd_val_s;
`endif

  // Ops that this build is able to execute.
  function automatic logic op_legal(input logic [1:0] op);
`ifdef IO_BUS_RMW_EN
    return (op == OP_RD) || (op == OP_WR) || (op == OP_SET) || (op == OP_CLR);
`else
    return (op == OP_RD) || (op == OP_WR);
`endif
  endfunction

`ifdef IO_BUS_RMW_EN
  // Apply a single-bit set or clear to a read value.
  function automatic logic [DATA_WIDTH-1:0] bit_modify(
    input logic [DATA_WIDTH-1:0] value,
    input logic [1:0]            op,
    input logic [BIT_W-1:0]      idx
  );
    logic [DATA_WIDTH-1:0] mask;
    mask = DATA_WIDTH'(1) << idx;
    case (op)
      OP_SET:  return value | mask;
      OP_CLR:  return value & ~mask;
      default: return value;
    endcase
  endfunction
`endif

  assign req_ready = (state_q == IDLE) && !reset;
  assign accept_s  = req_valid && req_ready;

  // State register.
  always_ff @(posedge clk) begin
    state_q <= state_d;
  end

  // Next-state logic; reset forces IDLE from any state, dropping the request.
  always_comb begin
    state_d = state_q;
    if (reset) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s && op_legal(req_op)) begin
            state_d = (req_op == OP_WR) ? WR : RD_ADDR;
          end else begin
            state_d = IDLE;
          end
        end
        RD_ADDR: state_d = RD_DATA;
`ifdef IO_BUS_RMW_EN
        RD_DATA: state_d = (op_q == OP_RD) ? IDLE : WR;
`else
        RD_DATA: state_d = IDLE;
`endif
        WR:      state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Output and datapath logic. Strobes are decoded from the next state so
  // the registered strobes line up with the state they belong to.
  always_comb begin
    bit_d       = bit_q;
    address_d   = address_q;
    wdata_d     = wdata_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_bit_d   = rsp_bit_q;
    rsp_err_d   = rsp_err_q;
    cs_d        = (state_d != IDLE);
    we_d        = (state_d == WR);
    oe_d        = (state_d == RD_DATA);
`ifdef IO_BUS_RMW_EN
    op_d        = op_q;
    rmw_d       = rmw_q;
    rd_val_s    = {DATA_WIDTH{1'b0}};
`endif
    if (reset) begin
      bit_d       = {BIT_W{1'b0}};
      address_d   = {ADDR_WIDTH{1'b0}};
      wdata_d     = {DATA_WIDTH{1'b0}};
      rsp_rdata_d = {DATA_WIDTH{1'b0}};
      rsp_bit_d   = 1'b0;
      rsp_err_d   = 1'b0;
      cs_d        = 1'b0;
      we_d        = 1'b0;
      oe_d        = 1'b0;
`ifdef IO_BUS_RMW_EN
      op_d        = 2'b00;
      rmw_d       = {DATA_WIDTH{1'b0}};
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (accept_s) begin
            bit_d = req_bit;
`ifdef IO_BUS_RMW_EN
            op_d  = req_op;
`endif
            if (op_legal(req_op)) begin
              address_d = req_addr;
              wdata_d   = req_wdata;
            end else begin
              // Rejected in the acceptance cycle with no bus activity.
              rsp_valid_d = 1'b1;
              rsp_err_d   = 1'b1;
              rsp_rdata_d = {DATA_WIDTH{1'b0}};
              rsp_bit_d   = 1'b0;
            end
          end else begin
            bit_d = bit_q;
          end
        end
        RD_DATA: begin
`ifdef IO_BUS_RMW_EN
          if (op_q == OP_RD) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = data;
            rsp_bit_d   = data[bit_q];
          end else begin
            rmw_d   = data;
            wdata_d = bit_modify(data, op_q, bit_q);
          end
`else
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
          rsp_rdata_d = data;
          rsp_bit_d   = data[bit_q];
`endif
        end
        WR: begin
          rsp_valid_d = 1'b1;
          rsp_err_d   = 1'b0;
`ifdef IO_BUS_RMW_EN
          rd_val_s    = (op_q == OP_WR) ? {DATA_WIDTH{1'b0}} : rmw_q;
          rsp_rdata_d = rd_val_s;
          rsp_bit_d   = rd_val_s[bit_q];
`else
          rsp_rdata_d = {DATA_WIDTH{1'b0}};
          rsp_bit_d   = 1'b0;
`endif
        end
        default: begin
          rsp_valid_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and strobe registers.
  always_ff @(posedge clk) begin
    bit_q       <= bit_d;
    address_q   <= address_d;
    wdata_q     <= wdata_d;
    cs_q        <= cs_d;
    we_q        <= we_d;
    oe_q        <= oe_d;
    rsp_valid_q <= rsp_valid_d;
    rsp_rdata_q <= rsp_rdata_d;
    rsp_bit_q   <= rsp_bit_d;
    rsp_err_q   <= rsp_err_d;
`ifdef IO_BUS_RMW_EN
    op_q        <= op_d;
    rmw_q       <= rmw_d;
`endif
  end

  assign cs        = cs_q;
  assign we        = we_q;
  assign oe        = oe_q;
  assign address   = address_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_bit   = rsp_bit_q;
  assign rsp_err   = rsp_err_q;

  // we_q is high only in WR, so the master drives data exactly then.
  assign data = we_q ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_io_bus_master.sv
// Directed bench for io_bus_master with a behavioural I/O register file that
// acts on the falling clock edge.
module tb_io_bus_master;

  logic       clk;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [1:0] req_op;
  logic [5:0] req_addr;
  logic [7:0] req_wdata;
  logic [2:0] req_bit;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_bit;
  logic       rsp_err;
  logic       cs;
  logic       we;
  logic       oe;
  logic [5:0] address;
  wire  [7:0] data;

  int checks   = 0;
  int failures = 0;
  int we_cnt   = 0;
  int weoe_cnt = 0;
  int we_snap;

  io_bus_master dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_bit   (req_bit),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_bit   (rsp_bit),
    .rsp_err   (rsp_err),
    .cs        (cs),
    .we        (we),
    .oe        (oe),
    .address   (address),
    .data      (data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // I/O register file model.
  logic [7:0] regs [64];
  logic [5:0] lat_addr;

  always @(negedge clk) begin
    if (cs && !we) lat_addr <= address;
    if (cs && we) regs[address] <= data;
    if (we) we_cnt <= we_cnt + 1;
    if (we && oe) weoe_cnt <= weoe_cnt + 1;
  end

  assign data = (cs && oe && !we) ? regs[lat_addr] : 8'hzz;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic [1:0] op, input logic [5:0] addr,
                     input logic [7:0] wd, input logic [2:0] b);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wd;
    req_bit   = b;
  endtask

  task automatic strobes(input string tag, input logic c, input logic w, input logic o);
    chk({tag, "_cs"}, {31'd0, cs}, {31'd0, c});
    chk({tag, "_we"}, {31'd0, we}, {31'd0, w});
    chk({tag, "_oe"}, {31'd0, oe}, {31'd0, o});
  endtask

  task automatic rsp(input string tag, input logic [7:0] rd, input logic b, input logic e);
    chk({tag, "_valid"}, {31'd0, rsp_valid}, 32'd1);
    chk({tag, "_rdata"}, {24'd0, rsp_rdata}, {24'd0, rd});
    chk({tag, "_bit"},   {31'd0, rsp_bit},   {31'd0, b});
    chk({tag, "_err"},   {31'd0, rsp_err},   {31'd0, e});
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_op    = 2'b00;
    req_addr  = 6'h00;
    req_wdata = 8'h00;
    req_bit   = 3'd0;
    tick(); tick(); tick();

    // Reset state
    strobes("rst", 1'b0, 1'b0, 1'b0);
    chk("rst_addr",  {26'd0, address},   32'd0);
    chk("rst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("rst_bit",   {31'd0, rsp_bit},   32'd0);
    chk("rst_err",   {31'd0, rsp_err},   32'd0);
    chk("rst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    chk("ready_after_rst", {31'd0, req_ready}, 32'd1);

    // Preload 0x1A=0x5C and 0x07=0x10 through the bus
    req(2'b01, 6'h1A, 8'h5C, 3'd0); tick(); req_valid = 1'b0; tick();
    req(2'b01, 6'h07, 8'h10, 3'd0); tick(); req_valid = 1'b0; tick();

    // Read 0x1A bit 2; later input changes must be ignored
    req(2'b00, 6'h1A, 8'h00, 3'd2);
    tick();
    req_valid = 1'b0; req_addr = 6'h3F; req_bit = 3'd0;
    strobes("rd_e0", 1'b1, 1'b0, 1'b0);
    chk("rd_e0_addr",  {26'd0, address},   32'h1A);
    chk("rd_e0_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rd_e0_ready", {31'd0, req_ready}, 32'd0);
    tick();
    strobes("rd_e1", 1'b1, 1'b0, 1'b1);
    chk("rd_e1_valid", {31'd0, rsp_valid}, 32'd0);
    tick();
    rsp("rd", 8'h5C, 1'b1, 1'b0);
    strobes("rd_e2", 1'b0, 1'b0, 1'b0);
    chk("rd_e2_ready", {31'd0, req_ready}, 32'd1);

    // Back-to-back write 0xA5 to 0x03 issued in the response cycle
    we_snap = we_cnt;
    req(2'b01, 6'h03, 8'hA5, 3'd2);
    tick();
    req_valid = 1'b0; req_wdata = 8'h00;
    strobes("wr_e0", 1'b1, 1'b1, 1'b0);
    chk("wr_e0_addr",  {26'd0, address},   32'h03);
    chk("wr_e0_data",  {24'd0, data},      32'hA5);
    chk("wr_e0_valid", {31'd0, rsp_valid}, 32'd0);
    chk("wr_e0_hold",  {24'd0, rsp_rdata}, 32'h5C);
    tick();
    rsp("wr", 8'h00, 1'b0, 1'b0);
    strobes("wr_e1", 1'b0, 1'b0, 1'b0);
    chk("wr_pulses", we_cnt - we_snap, 32'd1);
    chk("wr_reg03", {24'd0, regs[3]}, 32'hA5);
    chk("idle_addr_hold", {26'd0, address}, 32'h03);

    // Read back 0x03, bit 1
    req(2'b00, 6'h03, 8'h00, 3'd1);
    tick(); req_valid = 1'b0; tick(); tick();
    rsp("rb03", 8'hA5, 1'b0, 1'b0);

`ifdef IO_BUS_RMW_EN
    // Set bit 0 of 0x07 (0x10)
    req(2'b10, 6'h07, 8'h00, 3'd0);
    tick(); req_valid = 1'b0;
    strobes("set_e0", 1'b1, 1'b0, 1'b0);
    tick();
    strobes("set_e1", 1'b1, 1'b0, 1'b1);
    tick();
    strobes("set_e2", 1'b1, 1'b1, 1'b0);
    chk("set_e2_data",  {24'd0, data},      32'h11);
    chk("set_e2_valid", {31'd0, rsp_valid}, 32'd0);
    chk("set_e2_hold",  {24'd0, rsp_rdata}, 32'hA5);
    tick();
    rsp("set", 8'h10, 1'b0, 1'b0);
    chk("set_reg07", {24'd0, regs[7]}, 32'h11);

    // Clear bit 4, back-to-back
    req(2'b11, 6'h07, 8'h00, 3'd4);
    tick(); req_valid = 1'b0; tick(); tick();
    chk("clr_e2_data", {24'd0, data}, 32'h01);
    tick();
    rsp("clr", 8'h11, 1'b1, 1'b0);
    chk("clr_reg07", {24'd0, regs[7]}, 32'h01);

    // Reset during RD_DATA of a set bit 3 on 0x07
    we_snap = we_cnt;
    req(2'b10, 6'h07, 8'h00, 3'd3);
    tick(); req_valid = 1'b0; tick();
    reset = 1'b1;
    tick();
`else
    // Illegal op 10 on 0x07
    req(2'b10, 6'h07, 8'h00, 3'd4);
    tick(); req_valid = 1'b0;
    rsp("ill", 8'h00, 1'b0, 1'b1);
    strobes("ill_e0", 1'b0, 1'b0, 1'b0);
    chk("ill_ready", {31'd0, req_ready}, 32'd1);
    tick();
    chk("ill_e1_valid", {31'd0, rsp_valid}, 32'd0);
    chk("ill_e1_cs",    {31'd0, cs},        32'd0);
    chk("ill_err_hold", {31'd0, rsp_err},   32'd1);
    chk("ill_reg07", {24'd0, regs[7]}, 32'h10);

    // Illegal op 11, then a read that clears rsp_err
    req(2'b11, 6'h07, 8'h00, 3'd1);
    tick(); req_valid = 1'b0;
    rsp("ill11", 8'h00, 1'b0, 1'b1);
    req(2'b00, 6'h07, 8'h00, 3'd4);
    tick(); req_valid = 1'b0; tick();
    chk("err_hold_rd", {31'd0, rsp_err}, 32'd1);
    tick();
    rsp("rd07", 8'h10, 1'b1, 1'b0);

    // Reset during RD_DATA of a read
    we_snap = we_cnt;
    req(2'b00, 6'h07, 8'h00, 3'd4);
    tick(); req_valid = 1'b0; tick();
    reset = 1'b1;
    tick();
`endif
    strobes("mrst", 1'b0, 1'b0, 1'b0);
    chk("mrst_addr",  {26'd0, address},   32'd0);
    chk("mrst_valid", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_rdata", {24'd0, rsp_rdata}, 32'd0);
    chk("mrst_bit",   {31'd0, rsp_bit},   32'd0);
    chk("mrst_err",   {31'd0, rsp_err},   32'd0);
    chk("mrst_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    tick();
    chk("mrst_no_rsp", {31'd0, rsp_valid}, 32'd0);
    chk("mrst_no_we", we_cnt - we_snap, 32'd0);

    // Next read completes normally
    req(2'b00, 6'h07, 8'h00, 3'd0);
    tick(); req_valid = 1'b0; tick(); tick();
`ifdef IO_BUS_RMW_EN
    rsp("post_rst", 8'h01, 1'b1, 1'b0);
`else
    rsp("post_rst", 8'h10, 1'b0, 1'b0);
`endif

    chk("no_we_oe_overlap", weoe_cnt, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
